// File: rtl/sort8_ctrl.sv
// sort8_ctrl: collects eight signed words, bubble-sorts them in place with one
// shared signed compare per cycle, then streams them out smallest first.
module sort8_ctrl #(
  parameter int N = 8,
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_in_valid,
  output logic         o_in_ready,
  input  logic [W-1:0] i_in_data,
  output logic         o_out_valid,
  input  logic         i_out_ready,
  output logic [W-1:0] o_out_data,
  output logic         o_busy,
  output logic [4:0]   o_cmp_count
);

  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_SORT  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t              r_state;
  logic signed [W-1:0] r_buf [N];
  logic [2:0]          r_wr_ptr;
  logic [2:0]          r_rd_ptr;
  logic [2:0]          r_i;
  logic [2:0]          r_pass;
  logic                r_swapped;
  logic                r_in_ready;
  logic                r_out_valid;
  logic                r_busy;
  logic [4:0]          r_cmp_count;

  logic signed [W-1:0] w_a;
  logic signed [W-1:0] w_b;
  logic [2:0]          w_i_next;
  logic                w_le;
  logic                w_last;
  logic                w_swapped;
  logic                w_accept;
  logic                w_xfer;

  // Both operands are declared signed, so the compare is a true two's-complement
  // compare with no subtraction and hence no overflow hazard.
  assign w_i_next  = r_i + 3'd1;
  assign w_a       = r_buf[r_i];
  assign w_b       = r_buf[w_i_next];
  assign w_le      = (w_a <= w_b);
  assign w_last    = (r_i == (3'd6 - r_pass));
  assign w_swapped = r_swapped | ~w_le;
  assign w_accept  = (r_state == S_LOAD) && r_in_ready && i_in_valid;
  assign w_xfer    = (r_state == S_DRAIN) && r_out_valid && i_out_ready;

  assign o_in_ready  = r_in_ready;
  assign o_out_valid = r_out_valid;
  assign o_busy      = r_busy;
  assign o_cmp_count = r_cmp_count;
  assign o_out_data  = r_buf[r_rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_LOAD;
      r_wr_ptr    <= 3'd0;
      r_rd_ptr    <= 3'd0;
      r_i         <= 3'd0;
      r_pass      <= 3'd0;
      r_swapped   <= 1'b0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_cmp_count <= 5'd0;
      for (int k = 0; k < N; k++) begin
        r_buf[k] <= '0;
      end
    end else begin
      case (r_state)
        S_LOAD: begin
          r_in_ready <= 1'b1;
          if (w_accept) begin
            r_buf[r_wr_ptr] <= i_in_data;
            r_wr_ptr        <= r_wr_ptr + 3'd1;
            if (r_wr_ptr == 3'd7) begin
              r_state     <= S_SORT;
              r_wr_ptr    <= 3'd0;
              r_in_ready  <= 1'b0;
              r_busy      <= 1'b1;
              r_i         <= 3'd0;
              r_pass      <= 3'd0;
              r_swapped   <= 1'b0;
              r_cmp_count <= 5'd0;
            end
          end
        end

        S_SORT: begin
          r_cmp_count <= r_cmp_count + 5'd1;
          if (!w_le) begin
            r_buf[r_i]      <= w_b;
            r_buf[w_i_next] <= w_a;
          end
          // The pass-end decision folds in this cycle's swap via w_swapped.
          if (w_last) begin
            if (!w_swapped || (r_pass == 3'd6)) begin
              r_state     <= S_DRAIN;
              r_busy      <= 1'b0;
              r_out_valid <= 1'b1;
              r_rd_ptr    <= 3'd0;
            end else begin
              r_pass    <= r_pass + 3'd1;
              r_i       <= 3'd0;
              r_swapped <= 1'b0;
            end
          end else begin
            r_i       <= w_i_next;
            r_swapped <= w_swapped;
          end
        end

        S_DRAIN: begin
          if (w_xfer) begin
            r_rd_ptr <= r_rd_ptr + 3'd1;
            if (r_rd_ptr == 3'd7) begin
              r_state     <= S_LOAD;
              r_rd_ptr    <= 3'd0;
              r_wr_ptr    <= 3'd0;
              r_out_valid <= 1'b0;
              r_in_ready  <= 1'b1;
            end
          end
        end

        default: begin
          r_state     <= S_LOAD;
          r_in_ready  <= 1'b0;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sort8_ctrl.sv
// Bench for sort8_ctrl: a per-cycle reference model of the batch protocol plus
// literal expectations for each directed batch.
module tb_sort8_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        i_in_valid = 1'b0;
  logic        o_in_ready;
  logic [15:0] i_in_data = 16'h0000;
  logic        o_out_valid;
  logic        i_out_ready = 1'b0;
  logic [15:0] o_out_data;
  logic        o_busy;
  logic [4:0]  o_cmp_count;

  int n_vec = 0;
  int n_err = 0;

  // reference model state
  int          m_phase = 0;
  int          m_n = 0;
  int          m_idx = 0;
  int          m_c = 0;
  int          m_c_last = 0;
  int          m_left = 0;
  bit          m_fresh = 1'b1;
  logic [15:0] m_in [8];
  logic [15:0] m_exp [8];
  logic [15:0] got [128];
  int          got_n = 0;
  int          busy_total = 0;

  logic [15:0] t_w [8];
  logic [15:0] t_e [8];

  sort8_ctrl #(.N(8), .W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_in_valid (i_in_valid),
    .o_in_ready (o_in_ready),
    .i_in_data  (i_in_data),
    .o_out_valid(o_out_valid),
    .i_out_ready(i_out_ready),
    .o_out_data (o_out_data),
    .o_busy     (o_busy),
    .o_cmp_count(o_cmp_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Sorted order by signed value (insertion sort, independent of the DUT's algorithm).
  function automatic void ref_sort(input logic [15:0] a_in [8], output logic [15:0] a_out [8]);
    logic [15:0] v;
    int j;
    a_out = a_in;
    for (int k = 1; k < 8; k++) begin
      v = a_out[k];
      j = k - 1;
      while (j >= 0 && $signed(a_out[j]) > $signed(v)) begin
        a_out[j+1] = a_out[j];
        j--;
      end
      a_out[j+1] = v;
    end
  endfunction

  // Compare count of an early-exit bubble sort over 8 signed values.
  function automatic int ref_compares(input logic [15:0] a_in [8]);
    int a [8];
    int t;
    int cnt;
    bit sw;
    for (int k = 0; k < 8; k++) a[k] = $signed(a_in[k]);
    cnt = 0;
    for (int p = 0; p < 7; p++) begin
      sw = 1'b0;
      for (int j = 0; j < 7 - p; j++) begin
        cnt++;
        if (a[j] > a[j+1]) begin
          t = a[j]; a[j] = a[j+1]; a[j+1] = t;
          sw = 1'b1;
        end
      end
      if (!sw) break;
    end
    return cnt;
  endfunction

  task automatic run_monitor();
    bit exp_ready;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_in_ready", o_in_ready, 0);
        chk("rst_out_valid", o_out_valid, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_out_data", o_out_data, 0);
        chk("rst_cmp_count", o_cmp_count, 0);
        m_phase = 0; m_n = 0; m_idx = 0; m_fresh = 1'b1; m_c_last = 0;
      end else begin
        if (o_busy) busy_total++;
        case (m_phase)
          0: begin
            exp_ready = !m_fresh;
            m_fresh = 1'b0;
            chk("load_in_ready", o_in_ready, exp_ready);
            chk("load_out_valid", o_out_valid, 0);
            chk("load_busy", o_busy, 0);
            chk("load_cmp_count", o_cmp_count, m_c_last);
            if (i_in_valid && exp_ready) begin
              m_in[m_n] = i_in_data;
              m_n++;
              if (m_n == 8) begin
                ref_sort(m_in, m_exp);
                m_c = ref_compares(m_in);
                m_left = m_c;
                m_n = 0;
                m_phase = 1;
              end
            end
          end
          1: begin
            chk("sort_in_ready", o_in_ready, 0);
            chk("sort_out_valid", o_out_valid, 0);
            chk("sort_busy", o_busy, 1);
            chk("sort_cmp_count", o_cmp_count, m_c - m_left);
            m_left--;
            if (m_left == 0) begin
              m_phase = 2;
              m_idx = 0;
              m_c_last = m_c;
            end
          end
          default: begin
            chk("drain_in_ready", o_in_ready, 0);
            chk("drain_out_valid", o_out_valid, 1);
            chk("drain_busy", o_busy, 0);
            chk("drain_out_data", o_out_data, m_exp[m_idx]);
            chk("drain_cmp_count", o_cmp_count, m_c);
            if (i_out_ready) begin
              got[got_n] = o_out_data;
              got_n++;
              m_idx++;
              if (m_idx == 8) m_phase = 0;
            end
          end
        endcase
      end
    end
  endtask

  task automatic load_words(input logic [15:0] w [8], input int n, input bit gaps, input bit hold);
    bit acc;
    bit acc_now;
    int t;
    for (int k = 0; k < n; k++) begin
      if (gaps && (k % 3 == 1)) begin
        i_in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
      end
      i_in_valid = 1'b1;
      i_in_data  = w[k];
      acc = 1'b0;
      t = 0;
      while (!acc && t < 50) begin
        @(negedge clk);
        acc_now = o_in_ready;
        @(posedge clk);
        #1;
        acc = acc_now;
        t++;
      end
      if (!acc) begin
        n_vec++; n_err++;
        $display("FAIL load_timeout: word %0d got no in_ready expected accept within 50 cycles", k);
      end
    end
    i_in_valid = hold;
    i_in_data  = 16'hDEAD;
  endtask

  task automatic drain(input bit rnd, input int base);
    int t = 0;
    while ((got_n - base) < 8 && t < 400) begin
      i_out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk);
      #1;
      t++;
    end
    i_in_valid  = 1'b0;
    i_out_ready = 1'b0;
    if ((got_n - base) < 8) begin
      n_vec++; n_err++;
      $display("FAIL drain_timeout: got %0d transfers expected 8", got_n - base);
    end
  endtask

  task automatic run_batch(input string nm, input logic [15:0] w [8], input logic [15:0] e [8],
                           input int exp_c, input int exp_busy,
                           input bit gaps, input bit hold, input bit rnd);
    int base = got_n;
    int b0 = busy_total;
    load_words(w, 8, gaps, hold);
    drain(rnd, base);
    for (int k = 0; k < 8; k++) chk({nm, "_out"}, got[base+k], e[k]);
    if (exp_c >= 0) chk({nm, "_cmp_count"}, o_cmp_count, exp_c);
    if (exp_busy >= 0) chk({nm, "_busy_cycles"}, busy_total - b0, exp_busy);
    $display("batch %s: %0d outputs, cmp_count=%0d, busy cycles=%0d", nm, got_n - base, o_cmp_count, busy_total - b0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("reset_imm_in_ready", o_in_ready, 0);
    chk("reset_imm_out_valid", o_out_valid, 0);
    chk("reset_imm_busy", o_busy, 0);
    i_in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    fork
      run_monitor();
    join_none
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // reset mid-batch, then a fresh batch
    t_w = '{16'h0003, 16'h0001, 16'h0002, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    load_words(t_w, 3, 1'b0, 1'b0);
    do_reset();
    t_w = '{16'h0015, 16'h0013, 16'h0018, 16'h0011, 16'h0019, 16'h0012, 16'h0017, 16'h0014};
    t_e = '{16'h0011, 16'h0012, 16'h0013, 16'h0014, 16'h0015, 16'h0017, 16'h0018, 16'h0019};
    run_batch("after_reset", t_w, t_e, -1, -1, 1'b0, 1'b0, 1'b0);

    t_w = '{16'h0000, 16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005, 16'h0006, 16'h0007};
    t_e = t_w;
    run_batch("sorted", t_w, t_e, 7, 7, 1'b0, 1'b0, 1'b0);

    t_w = '{16'h0007, 16'h0006, 16'h0005, 16'h0004, 16'h0003, 16'h0002, 16'h0001, 16'h0000};
    t_e = '{16'h0000, 16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005, 16'h0006, 16'h0007};
    run_batch("descending", t_w, t_e, 28, 28, 1'b0, 1'b0, 1'b0);

    t_w = '{16'h7FFF, 16'h8000, 16'h0000, 16'hFFFF, 16'h0001, 16'h8001, 16'h7FFE, 16'h0000};
    t_e = '{16'h8000, 16'h8001, 16'hFFFF, 16'h0000, 16'h0000, 16'h0001, 16'h7FFE, 16'h7FFF};
    run_batch("overflow", t_w, t_e, -1, -1, 1'b0, 1'b0, 1'b0);

    t_w = '{16'h0007, 16'h0006, 16'h0005, 16'h0004, 16'h0003, 16'h0002, 16'h0001, 16'h0000};
    t_e = '{16'h0000, 16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005, 16'h0006, 16'h0007};
    run_batch("backpressure", t_w, t_e, 28, 28, 1'b0, 1'b0, 1'b1);

    t_w = '{16'h0100, 16'hFF00, 16'h0000, 16'h0100, 16'h8000, 16'h0005, 16'hFFFF, 16'h7FFF};
    t_e = '{16'h8000, 16'hFF00, 16'hFFFF, 16'h0000, 16'h0005, 16'h0100, 16'h0100, 16'h7FFF};
    run_batch("stream_gaps", t_w, t_e, -1, -1, 1'b1, 1'b1, 1'b0);

    t_w = '{16'h0000, 16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005, 16'h0006, 16'h0007};
    t_e = t_w;
    run_batch("stream_second", t_w, t_e, 7, 7, 1'b0, 1'b1, 1'b0);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sort8_ctrl.md
# sort8_ctrl

Sequential sorting controller that shares a single signed less-than-or-equal compare unit across an internal 8-entry, 16-bit register buffer. The block accepts 8 signed words over a valid/ready input stream and bubble-sorts them in place into ascending signed order, using one compare and one conditional swap per cycle. It then streams the sorted words out over a valid/ready output stream. It sits downstream of the ALU datapath as the first sequenced consumer of the signed comparison function.

## Interface
- N, 8, number of words per batch (fixed at 8; counters sized for 8)
- W, 16, word width in bits, two's complement
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  in_data is valid this cycle
- in_ready  out  1  block accepts a word this cycle; high only in LOAD
- in_data  in  16  signed input word
- out_valid  out  1  out_data is valid; high only in DRAIN
- out_ready  in  1  downstream accepts out_data
- out_data  out  16  sorted word, smallest first
- busy  out  1  high in SORT
- cmp_count  out  5  number of compare cycles used by the most recent sort (max 28)

## Operation
- The state machine has three states: LOAD, SORT and DRAIN. Reset enters LOAD.
- **LOAD**
  - in_ready=1.
  - Each cycle with in_valid&&in_ready writes in_data to buf[wr_ptr] and increments wr_ptr.
  - On the 8th accept, the next state is SORT.
  - i, pass and swapped are cleared. cmp_count is cleared to 0.
- **SORT**
  - One compare per cycle: le = (buf[i] <= buf[i+1]), a true signed comparison.
  - Overflow must not corrupt the result: 0x7FFF vs 0x8000 gives le=0, and 0x8000 vs 0x7FFF gives le=1.
  - If le=0, buf[i] and buf[i+1] are swapped and swapped is set. Equal values are never swapped, so the sort is stable.
  - cmp_count increments every SORT cycle.
  - i runs 0..(6-pass). At the end of a pass (i==6-pass):
    - If swapped==0 after the update, or pass==6, the next state is DRAIN.
    - Otherwise pass increments, i returns to 0 and swapped is cleared.
  - The swapped test at the end of a pass includes the swap decision of that final cycle.
- **DRAIN**
  - out_valid=1 and out_data=buf[rd_ptr].
  - Each out_valid&&out_ready increments rd_ptr.
  - On the 8th transfer, the next state is LOAD with wr_ptr=rd_ptr=0.
  - out_data must hold stable while out_valid&&!out_ready.
- in_valid is ignored outside LOAD. out_ready is ignored outside DRAIN.
- cmp_count holds its value from the end of SORT until the next LOAD→SORT transition.

## Timing
- **Reset values** (asynchronous, immediate on rst_n=0):
  - state=LOAD, all pointers=0, all buffer entries=0, cmp_count=0.
  - Outputs during reset: in_ready=0, out_valid=0, busy=0, out_data=0.
  - in_ready rises in the first cycle after rst_n deasserts.
- Reset mid-operation, in any state, discards the batch. The block returns to empty LOAD with no partial output.
- in_ready, out_valid and busy are decoded from registered state. in_ready does not depend combinationally on in_valid. out_valid does not depend combinationally on out_ready.
- **Latency.** Let the 8th input be accepted at edge t.
  - SORT occupies cycles t+1..t+C, where C=cmp_count.
  - out_valid rises in cycle t+C+1.
  - Best case (already sorted): C=7.
  - Worst case (strictly descending): C=28.
- **Throughput.** Input is 1 word/cycle. Output is 1 word/cycle with out_ready held high.
  - Back-to-back batches: the cycle after the 8th output handshake, in_ready=1.
- No input is accepted while in SORT or DRAIN, even if in_valid is held high.

## Test plan
- **Reset mid-batch.** Load 0x0003, 0x0001, 0x0002, then assert rst_n=0. Required response:
  - out_valid and in_ready drop immediately.
  - After release, load 8 new words; output contains only the new words, sorted.
- **Sorted input.** Load 0x0000..0x0007. Required response:
  - cmp_count=7.
  - out_valid rises 8 cycles after the last accept.
  - Output is 0..7 in order.
- **Descending input.** Load 0x0007..0x0000. Required response:
  - cmp_count=28.
  - busy is high for exactly 28 cycles.
  - Output is 0..7.
- **Overflow corners.** Load 0x7FFF, 0x8000, 0x0000, 0xFFFF, 0x0001, 0x8001, 0x7FFE, 0x0000. Required response:
  - Output is 0x8000, 0x8001, 0xFFFF, 0x0000, 0x0000, 0x0001, 0x7FFE, 0x7FFF.
- **Output backpressure.** With descending input, toggle out_ready randomly. Required response:
  - out_data holds stable while stalled.
  - Exactly 8 transfers occur, correctly ordered.
  - in_ready rises only after the 8th transfer.
- **Stream protocol.** Hold in_valid=1 throughout SORT/DRAIN and insert input gaps during LOAD. Required response:
  - Only 8 words are accepted per batch.
  - A second batch loaded immediately after drain sorts correctly, with cmp_count recomputed.
